// File: rtl/hazard_pkg.sv
// Opcode constants and source/destination decode helpers for the ID-stage hazard unit.
// Shared by load_use_scoreboard and hazard_reg_timer.
package hazard_pkg;

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;

    function automatic logic uses_rs1(input logic [4:0] opc);
        case (opc)
            OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: uses_rs1 = 1'b1;
            default: uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [4:0] opc);
        case (opc)
            OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
            default: uses_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [4:0] opc);
        case (opc)
            OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: writes_rd = 1'b1;
            default: writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_reg_timer.sv
// Per-register load-latency down-counter: load on a LOAD issue, clear on a newer producer,
// otherwise decrement toward zero; everything holds while the pipeline is frozen.
module hazard_reg_timer
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic advance,
    input  logic load,
    input  logic clear,
    output logic busy,
    output logic busy_nxt
);

    localparam int TW = $clog2(LOAD_LAT + 1);

    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_nxt;

    // A load issued in the same slot as the decrement restarts the full latency.
    always_comb begin
        cnt_nxt = cnt;
        if (advance) begin
            if (load)
                cnt_nxt = TW'(LOAD_LAT);
            else if (clear)
                cnt_nxt = '0;
            else if (cnt != '0)
                cnt_nxt = cnt - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

    assign busy     = (cnt != '0);
    assign busy_nxt = (cnt_nxt != '0);

endmodule

// File: rtl/load_use_scoreboard.sv
// Decode-stage load-use scoreboard: stalls ID while a source register awaits a load result.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module load_use_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NREG     = 32,
    parameter  int LOAD_LAT = 1,
    parameter  int CNT_W    = 16,
    localparam int AW       = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_opcode,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic [AW-1:0]    id_rd,
    input  logic             mem_busy,
    input  logic             flush,
    output logic             stall_id,
    output logic             pend_any,
    output logic [CNT_W-1:0] stall_cycles
);

    logic            dec_rs1;
    logic            dec_rs2;
    logic            dec_wr;
    logic            dec_load;
    logic            hz_rs1;
    logic            hz_rs2;
    logic            advance;
    logic            issue;
    logic            set_rd;
    logic            clr_rd;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    assign dec_rs1  = uses_rs1(id_opcode);
    assign dec_rs2  = uses_rs2(id_opcode);
    assign dec_wr   = writes_rd(id_opcode);
    assign dec_load = (id_opcode == OPC_LOAD);

    // x0 is hardwired zero and never becomes pending.
    assign busy[0]     = 1'b0;
    assign busy_nxt[0] = 1'b0;

    assign hz_rs1   = dec_rs1 && (id_rs1 != '0) && busy[id_rs1];
    assign hz_rs2   = dec_rs2 && (id_rs2 != '0) && busy[id_rs2];
    assign stall_id = id_valid && !flush && (hz_rs1 || hz_rs2);

    assign advance = !mem_busy;
    assign issue   = id_valid && !flush && !stall_id && advance;
    assign set_rd  = issue && dec_load && (id_rd != '0);
    assign clr_rd  = issue && dec_wr && !dec_load && (id_rd != '0);

    for (genvar r = 1; r < NREG; r++) begin : g_timer
        hazard_reg_timer #(
            .LOAD_LAT (LOAD_LAT)
        ) u_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .advance  (advance),
            .load     (set_rd && (id_rd == AW'(r))),
            .clear    (clr_rd && (id_rd == AW'(r))),
            .busy     (busy[r]),
            .busy_nxt (busy_nxt[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend_any <= 1'b0;
        else
            pend_any <= |busy_nxt;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_q;

    // Only frozen-free stall cycles count: a cache-miss freeze is not a hazard bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_q <= '0;
        else if (stall_id && advance && (perf_q != '1))
            perf_q <= perf_q + CNT_W'(1);
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Randomized self-checking bench: two scoreboard instances (LOAD_LAT=1 and LOAD_LAT=3/CNT_W=4)
// checked against a per-register remaining-slots model.
module tb_load_use_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       mem_busy;
    logic       flush;

    logic        stall_a, stall_b, pend_a, pend_b;
    logic [15:0] sc_a;
    logic [3:0]  sc_b;

    int checks = 0;
    int errors = 0;

    int mcnt [2][32];
    int mperf[2];
    int lat  [2] = '{1, 3};
    int cmax [2] = '{65535, 15};

    always #5 clk = ~clk;

    load_use_scoreboard #(.NREG(32), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .mem_busy(mem_busy),
        .flush(flush), .stall_id(stall_a), .pend_any(pend_a), .stall_cycles(sc_a));

    load_use_scoreboard #(.NREG(32), .LOAD_LAT(3), .CNT_W(4)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .mem_busy(mem_busy),
        .flush(flush), .stall_id(stall_b), .pend_any(pend_b), .stall_cycles(sc_b));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_rs1(input logic [4:0] o);
        return o inside {5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11001};
    endfunction
    function automatic bit m_rs2(input logic [4:0] o);
        return o inside {5'b01100, 5'b01000, 5'b11000};
    endfunction
    function automatic bit m_wr(input logic [4:0] o);
        return o inside {5'b01100, 5'b00100, 5'b00000, 5'b11011, 5'b11001, 5'b01101, 5'b00101};
    endfunction

    function automatic bit m_stall(input int k);
        bit h1, h2;
        h1 = m_rs1(id_opcode) && id_rs1 != 0 && mcnt[k][id_rs1] != 0;
        h2 = m_rs2(id_opcode) && id_rs2 != 0 && mcnt[k][id_rs2] != 0;
        return id_valid && !flush && (h1 || h2);
    endfunction

    function automatic int perf_exp(input int k);
`ifdef HAZARD_PERF_CNT_EN
        return mperf[k];
`else
        return 0;
`endif
    endfunction

    function automatic bit m_pend(input int k);
        for (int r = 0; r < 32; r++)
            if (mcnt[k][r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mperf[k] = 0;
            for (int r = 0; r < 32; r++) mcnt[k][r] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_pend1"}, pend_a, m_pend(0));
        check({tag, "_pend3"}, pend_b, m_pend(1));
        check({tag, "_perf1"}, sc_a, perf_exp(0));
        check({tag, "_perf3"}, sc_b, perf_exp(1));
    endtask

    // One clock: inputs applied in the low phase, stall checked before the edge, state after.
    task automatic cycle(input string tag, input bit v, input logic [4:0] opc,
                         input int rs1, input int rs2, input int rd, input bit mb, input bit fl);
        bit st[2];
        id_valid = v; id_opcode = opc; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
        mem_busy = mb; flush = fl;
        #1;
        st[0] = m_stall(0);
        st[1] = m_stall(1);
        check({tag, "_stall1"}, stall_a, st[0]);
        check({tag, "_stall3"}, stall_b, st[1]);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!mb) begin
                if (st[k] && mperf[k] < cmax[k]) mperf[k]++;
                for (int r = 0; r < 32; r++)
                    if (mcnt[k][r] > 0) mcnt[k][r]--;
                if (v && !fl && !st[k] && rd != 0) begin
                    if (opc == 5'b00000) mcnt[k][rd] = lat[k];
                    else if (m_wr(opc)) mcnt[k][rd] = 0;
                end
            end
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    localparam logic [4:0] LD = 5'b00000, ADD = 5'b01100, ADDI = 5'b00100, SW = 5'b01000;

    logic [4:0] opc_tbl [10] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                                 5'b11011, 5'b11001, 5'b01101, 5'b00101, 5'b11100};

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        mem_busy = 0; flush = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check("reset_stall1", stall_a, 0);
        check("reset_stall3", stall_b, 0);
        check_outputs("reset");
        rst_n = 1'b1;

        // Load followed by an immediate dependant; rs1=x0 never stalls.
        cycle("ld1", 1, LD, 1, 0, 5, 0, 0);
        repeat (4) cycle("dep1", 1, ADD, 5, 7, 6, 0, 0);
        cycle("ldx0", 1, LD, 1, 0, 0, 0, 0);
        cycle("usex0", 1, ADD, 0, 0, 6, 0, 0);

        // Cache-miss freeze holds the pending counter.
        cycle("ld2", 1, LD, 1, 0, 5, 0, 0);
        repeat (4) cycle("frz", 1, ADD, 5, 7, 6, 1, 0);
        repeat (4) cycle("thaw", 1, ADD, 5, 7, 6, 0, 0);

        // Newer independent producer clears the pending load.
        cycle("ld3", 1, LD, 1, 0, 5, 0, 0);
        cycle("addi", 1, ADDI, 1, 0, 5, 0, 0);
        cycle("sw", 1, SW, 2, 5, 0, 0, 0);

        // Flush masks a stall without issuing.
        cycle("ld4", 1, LD, 1, 0, 5, 0, 0);
        repeat (2) cycle("fl", 1, ADD, 5, 7, 6, 0, 1);
        repeat (3) cycle("afl", 1, ADD, 5, 7, 6, 0, 0);

        // Long stall run exercises counter saturation on the narrow instance.
        cycle("ld5", 1, LD, 1, 0, 9, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle("sat", 1, ADD, 9, 3, 4, 0, 0);
            cycle("relo", 1, LD, 1, 0, 9, 0, 0);
        end

        for (int i = 0; i < 3000; i++) begin
            int  rs1, rs2, rd;
            logic [4:0] opc;
            opc = ($urandom_range(0, 2) == 0) ? LD : opc_tbl[$urandom_range(0, 9)];
            rs1 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            rd  = $urandom_range(0, 7);
            cycle("rnd", $urandom_range(0, 9) != 0, opc, rs1, rs2, rd,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end

        // Asynchronous reset in the middle of a stall.
        cycle("ld6", 1, LD, 1, 0, 5, 0, 0);
        id_valid = 1; id_opcode = ADD; id_rs1 = 5'd5; id_rs2 = 5'd7; id_rd = 5'd6;
        mem_busy = 0; flush = 0;
        #1;
        check("prerst_stall3", stall_b, 1);
        rst_n = 1'b0;
        #1;
        model_clear();
        check("arst_stall1", stall_a, 0);
        check("arst_stall3", stall_b, 0);
        check_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst", 1, ADD, 5, 7, 6, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
